// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch queue: the queued entry layout,
// the NOP that empty slots present, and the decode-take clamp.
package fetch_queue_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            bp_en;
    logic            bp_taken;
  } fetch_entry_t;

  // Decode can retire at most two entries per cycle; a request of 3 means 2.
  function automatic logic [1:0] clamp_take(input logic [1:0] take);
    logic [1:0] result;
    case (take)
      2'd3:    result = 2'd2;
      default: result = take;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: one synchronous write port and two
// asynchronous read ports. Contents are not reset; validity lives in the count.
module fetch_queue_mem
  import fetch_queue_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         we,
  input  logic [PW-1:0] waddr,
  input  fetch_entry_t wdata,
  input  logic [PW-1:0] raddr0,
  input  logic [PW-1:0] raddr1,
  output fetch_entry_t rdata0,
  output fetch_entry_t rdata1
);

  fetch_entry_t entries_q [DEPTH];

  // Write the incoming entry at the tail slot.
  always_ff @(posedge clk) begin
    if (we) begin
      entries_q[waddr] <= wdata;
    end
  end

  assign rdata0 = entries_q[raddr0];
  assign rdata1 = entries_q[raddr1];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: circular buffer with one enqueue and up
// to two dequeues per cycle, flush-to-empty, and NOP-valued empty slots.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             enq_valid,
  input  logic [WIDTH-1:0] enq_pc,
  input  logic [WIDTH-1:0] enq_inst,
  input  logic             enq_bp_en,
  input  logic             enq_bp_taken,
  output logic             enq_ready,
  input  logic [1:0]       deq_take,
  output logic             deq_valid0,
  output logic             deq_valid1,
  output logic [WIDTH-1:0] deq_pc0,
  output logic [WIDTH-1:0] deq_pc1,
  output logic [WIDTH-1:0] deq_inst0,
  output logic [WIDTH-1:0] deq_inst1,
  output logic             deq_bp_en0,
  output logic             deq_bp_en1,
  output logic             deq_bp_taken0,
  output logic             deq_bp_taken1,
  output logic [CW-1:0]    count
);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_enq_s;
  logic [1:0]    take_s;
  logic [1:0]    eff_deq_s;
  fetch_entry_t  wr_entry_s;
  fetch_entry_t  rd0_s, rd1_s;

  // Readiness looks only at registered occupancy, so a same-cycle dequeue
  // never makes room for that cycle's enqueue.
  assign enq_ready = (count_q < CW'(DEPTH));
  assign do_enq_s  = enq_valid && enq_ready && !flush;
  assign count     = count_q;

  assign wr_entry_s.pc       = enq_pc;
  assign wr_entry_s.inst     = enq_inst;
  assign wr_entry_s.bp_en    = enq_bp_en;
  assign wr_entry_s.bp_taken = enq_bp_taken;

  fetch_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk    (clk),
    .we     (do_enq_s),
    .waddr  (tail_q),
    .wdata  (wr_entry_s),
    .raddr0 (head_q),
    .raddr1 (head_q + PW'(1'b1)),
    .rdata0 (rd0_s),
    .rdata1 (rd1_s)
  );

  // Next pointer/occupancy state; flush wins over everything else.
  always_comb begin
    take_s = clamp_take(deq_take);
    if (count_q >= CW'(take_s)) begin
      eff_deq_s = take_s;
    end else begin
      eff_deq_s = count_q[1:0];
    end
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(eff_deq_s);
      tail_d  = tail_q + PW'(do_enq_s);
      count_d = count_q + CW'(do_enq_s) - CW'(eff_deq_s);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign deq_valid0 = (count_q != '0);
  assign deq_valid1 = (count_q >= CW'(2'd2));

  // Slot presentation: empty slots show PC 0, NOP and no prediction.
  always_comb begin
    if (deq_valid0) begin
      deq_pc0       = rd0_s.pc;
      deq_inst0     = rd0_s.inst;
      deq_bp_en0    = rd0_s.bp_en;
      deq_bp_taken0 = rd0_s.bp_taken;
    end else begin
      deq_pc0       = '0;
      deq_inst0     = NOP_INST;
      deq_bp_en0    = 1'b0;
      deq_bp_taken0 = 1'b0;
    end
    if (deq_valid1) begin
      deq_pc1       = rd1_s.pc;
      deq_inst1     = rd1_s.inst;
      deq_bp_en1    = rd1_s.bp_en;
      deq_bp_taken1 = rd1_s.bp_taken;
    end else begin
      deq_pc1       = '0;
      deq_inst1     = NOP_INST;
      deq_bp_en1    = 1'b0;
      deq_bp_taken1 = 1'b0;
    end
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameters SHALL be:
- WIDTH, default 32: PC and instruction width.
- DEPTH, default 8: entry count; power of two, at least 4.
REQ-002 clk  input  1  rising-edge clock; the block's only clock.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 flush  input  1  redirect (branch correction or jump); discards all queued and incoming entries.
REQ-005 enq_valid  input  1  fetch stage presents an entry.
REQ-006 enq_pc  input  WIDTH  PC of the fetched instruction.
REQ-007 enq_inst  input  WIDTH  instruction word from instruction memory.
REQ-008 enq_bp_en  input  1  fetch-decoder branch flag.
REQ-009 enq_bp_taken  input  1  combined Gshare/loop predictor decision.
REQ-010 enq_ready  output  1  queue can accept an entry this cycle.
REQ-011 deq_take  input  2  number of entries decode consumes this cycle (0, 1 or 2).
REQ-012 deq_valid0 / deq_valid1  output  1 each  slot 0 (oldest) and slot 1 (second oldest) hold valid entries.
REQ-013 deq_pc0 / deq_pc1  output  WIDTH each  slot PCs.
REQ-014 deq_inst0 / deq_inst1  output  WIDTH each  slot instructions.
REQ-015 deq_bp_en0 / deq_bp_en1 and deq_bp_taken0 / deq_bp_taken1  output  1 each  slot prediction fields.
REQ-016 count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-017 Storage SHALL be a circular buffer with head and tail pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-018 enq_ready SHALL be (count < DEPTH), computed from registered state only; a dequeue in the same cycle SHALL NOT free a slot for that cycle's enqueue.
REQ-019 An enqueue SHALL occur when enq_valid && enq_ready && !flush; the entry is written at tail and tail advances by 1.
REQ-020 The effective dequeue SHALL be min(deq_take, count). deq_take=3 SHALL be treated as 2. Head advances by the effective dequeue modulo DEPTH.
REQ-021 Next count SHALL be count + enqueue - effective dequeue; the total SHALL stay within 0..DEPTH.
REQ-022 Slot outputs SHALL be combinational reads of entries head and head+1 (modulo DEPTH).
REQ-023 deq_valid0 SHALL equal (count >= 1) and deq_valid1 SHALL equal (count >= 2).
REQ-024 An invalid slot SHALL drive:
- pc = 0
- inst = 32'h00000013 (NOP)
- bp_en = 0, bp_taken = 0.
REQ-025 There SHALL be no enqueue-to-dequeue bypass: an entry written at edge N is first visible on slot 0 after edge N.
REQ-026 Flush SHALL take priority over enqueue and dequeue: at the next edge head, tail and count become 0 and that cycle's enqueue is dropped.
REQ-027 Enqueue at full (count=DEPTH) SHALL be ignored with state unchanged. Dequeue at empty SHALL be a no-op.
REQ-028 Entries SHALL be returned in exact enqueue order across pointer wrap-around.

Reset
REQ-029 While rst=0: head, tail and count SHALL be 0; deq_valid0/1 = 0; enq_ready = 1; slot outputs at NOP values.
REQ-030 Entry storage SHALL NOT require reset; validity derives from count alone.
REQ-031 Reset asserted mid-operation SHALL discard all entries immediately; the first enqueue after release is visible one cycle later.

Structure
REQ-032 A shared package SHALL define:
- fetch_entry_t {pc, inst, bp_en, bp_taken}
- NOP_INST = 32'h00000013.
REQ-033 Storage SHALL be one sub-module, fetch_queue_mem: DEPTH x fetch_entry_t, one synchronous write port, two asynchronous read ports.
REQ-034 Pointer, count and flush logic SHALL reside in fetch_queue.

Verification
REQ-035 Reset then enqueue PC 0x00, 0x04, 0x08 on three cycles with deq_take=0 -> count=3; slot0 PC=0x00, slot1 PC=0x04; deq_valid0=deq_valid1=1.
REQ-036 Fill to 8 entries, hold enq_valid=1 with deq_take=2 for one cycle -> that cycle's enqueue rejected (enq_ready=0); count=6 next cycle; no entry overwritten.
REQ-037 Enqueue 12 sequential PCs 0x100..0x12C while consuming 1 per cycle -> PCs emerge in order across the wrap, none lost or duplicated.
REQ-038 count=5, flush=1 with enq_valid=1 and deq_take=2 -> next cycle count=0, deq_valid0=0, deq_inst0=0x00000013.
REQ-039 count=1, deq_take=2 -> effective dequeue 1, count=0; no underflow.
REQ-040 Assert rst=0 asynchronously between edges with count=4 -> deq_valid0 falls before the next edge; enq_ready=1.
